dram_bank_responder: RTL and testbench

DRAM_BANK_RESPONDER -- requirements
Module: dram_bank_responder

---
 rtl/dram_bank_responder.sv | 187 ++++++++++++++++++
 tb/tb_dram_bank_responder.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/dram_bank_responder.sv
// rtl/dram_bank_responder.sv - single-bank DRAM timing responder (closed page; open page with DRAM_OPEN_PAGE_EN)
module dram_bank_responder #(
  parameter int TRCD        = 8,
  parameter int TCL         = 8,
  parameter int TRP         = 8,
  parameter int TWR         = 7,
  parameter int BURST_LEN   = 1,
  parameter int BEAT_W      = 64,
  parameter int NUM_ROWS    = 100,
  parameter int ADDRESS_LEN = 10
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic                        req_write,
  input  logic [ADDRESS_LEN-1:0]      req_addr,
  input  logic [BEAT_W*BURST_LEN-1:0] req_wdata,
  output logic                        resp_valid,
  output logic                        resp_write,
  output logic                        resp_err,
  output logic [BEAT_W-1:0]           resp_rdata,
  output logic                        busy
);

  localparam int ROW_W  = BEAT_W * BURST_LEN;
  localparam int MAX_A  = (TRCD > TCL) ? TRCD : TCL;
  localparam int MAX_B  = (TRP > TWR) ? TRP : TWR;
  localparam int MAX_C  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int MAX_D  = (MAX_C > BURST_LEN) ? MAX_C : BURST_LEN;
  localparam int CNT_W  = $clog2(MAX_D + 1);
  localparam int ROW_AW = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;

  localparam logic [CNT_W-1:0] LD_TRCD = CNT_W'(TRCD - 1);
  localparam logic [CNT_W-1:0] LD_TCL  = CNT_W'(TCL - 1);
  localparam logic [CNT_W-1:0] LD_TRP  = CNT_W'(TRP - 1);
  localparam logic [CNT_W-1:0] LD_TWR  = CNT_W'(TWR - 1);
  localparam logic [CNT_W-1:0] LD_BL   = CNT_W'(BURST_LEN - 1);

  localparam logic [2:0] S_IDLE        = 3'd0;
  localparam logic [2:0] S_ACTIVATE    = 3'd1;
  localparam logic [2:0] S_CAS         = 3'd2;
  localparam logic [2:0] S_BURST       = 3'd3;
  localparam logic [2:0] S_WRITE_RECOV = 3'd4;
  localparam logic [2:0] S_PRECHARGE   = 3'd5;

  logic [ROW_W-1:0]  mem [NUM_ROWS];
  logic [2:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic              is_write;
  logic [ROW_AW-1:0] row_q;
  logic [ROW_W-1:0]  wdata_q;
  logic              err_q;
  logic [BEAT_W-1:0] rdata_q;
  logic              addr_bad;
  logic [ROW_AW-1:0] req_row;
  logic              burst_rd;
  logic              burst_wr_last;
  int                beat_off;
  logic [BEAT_W-1:0] beat_now;

`ifdef DRAM_OPEN_PAGE_EN
  logic              row_open;
  logic [ROW_AW-1:0] open_row;
`endif

  assign addr_bad = 32'(req_addr) >= 32'(NUM_ROWS);
  assign req_row  = req_addr[ROW_AW-1:0];

  // The counter runs BURST_LEN-1 .. 0 in BURST, so beat k sits at offset (BL-1-cnt).
  assign beat_off      = (BURST_LEN - 1 - int'(cnt)) * BEAT_W;
  assign beat_now      = mem[row_q][beat_off +: BEAT_W];
  assign burst_rd      = (state == S_BURST) && !is_write;
  assign burst_wr_last = (state == S_BURST) && is_write && (cnt == '0);

  assign req_ready  = (state == S_IDLE);
  assign busy       = (state != S_IDLE);
  assign resp_valid = burst_rd || burst_wr_last || err_q;
  assign resp_write = burst_wr_last;
  assign resp_err   = err_q;
  assign resp_rdata = burst_rd ? beat_now : rdata_q;

  always_ff @(posedge clk) begin
    if ((state == S_BURST) && is_write)
      mem[row_q][beat_off +: BEAT_W] <= wdata_q[beat_off +: BEAT_W];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      is_write <= 1'b0;
      row_q    <= '0;
      wdata_q  <= '0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
`ifdef DRAM_OPEN_PAGE_EN
      row_open <= 1'b0;
      open_row <= '0;
`endif
    end else begin
      err_q <= 1'b0;
      if (burst_rd)
        rdata_q <= beat_now;
      if ((state != S_IDLE) && (cnt != '0)) begin
        cnt <= cnt - 1'b1;
      end else begin
        case (state)
          S_IDLE: begin
            if (req_valid) begin
              if (addr_bad) begin
                err_q <= 1'b1;
              end else begin
                is_write <= req_write;
                row_q    <= req_row;
                wdata_q  <= req_wdata;
`ifdef DRAM_OPEN_PAGE_EN
                if (row_open && (open_row == req_row)) begin
                  state <= S_CAS;
                  cnt   <= LD_TCL;
                end else if (row_open) begin
                  state <= S_PRECHARGE;
                  cnt   <= LD_TRP;
                end else begin
                  state <= S_ACTIVATE;
                  cnt   <= LD_TRCD;
                end
`else
                state <= S_ACTIVATE;
                cnt   <= LD_TRCD;
`endif
              end
            end
          end
          S_ACTIVATE: begin
            state <= S_CAS;
            cnt   <= LD_TCL;
`ifdef DRAM_OPEN_PAGE_EN
            row_open <= 1'b1;
            open_row <= row_q;
`endif
          end
          S_CAS: begin
            state <= S_BURST;
            cnt   <= LD_BL;
          end
          S_BURST: begin
            if (is_write) begin
              state <= S_WRITE_RECOV;
              cnt   <= LD_TWR;
            end else begin
`ifdef DRAM_OPEN_PAGE_EN
              state <= S_IDLE;
`else
              state <= S_PRECHARGE;
              cnt   <= LD_TRP;
`endif
            end
          end
          S_WRITE_RECOV: begin
`ifdef DRAM_OPEN_PAGE_EN
            state <= S_IDLE;
`else
            state <= S_PRECHARGE;
            cnt   <= LD_TRP;
`endif
          end
          S_PRECHARGE: begin
`ifdef DRAM_OPEN_PAGE_EN
            // Precharge is only entered on a row miss, so the new row is activated next.
            row_open <= 1'b0;
            state    <= S_ACTIVATE;
            cnt      <= LD_TRCD;
`else
            state <= S_IDLE;
`endif
          end
          default: begin
            state <= S_IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dram_bank_responder.sv
// tb/tb_dram_bank_responder.sv - directed vector bench for dram_bank_responder
module tb_dram_bank_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [9:0]  req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic        req_ready, resp_valid, resp_write, resp_err, busy;
  logic [63:0] resp_rdata;

  logic        b_req_valid = 1'b0;
  logic        b_req_ready, b_resp_valid, b_resp_write, b_resp_err, b_busy;
  logic [15:0] b_resp_rdata;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dram_bank_responder dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_write(resp_write), .resp_err(resp_err),
    .resp_rdata(resp_rdata), .busy(busy)
  );

  dram_bank_responder #(.BURST_LEN(4), .BEAT_W(16)) dut_bl4 (
    .clk(clk), .rst_n(rst_n), .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(b_resp_valid), .resp_write(b_resp_write), .resp_err(b_resp_err),
    .resp_rdata(b_resp_rdata), .busy(b_busy)
  );

  typedef struct {
    logic        wr;
    logic [9:0]  addr;
    logic [63:0] wdata;
    logic        err;
    int          resp_cyc;
    logic [63:0] rdata;
    int          ready_cyc;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic start(input logic wr, input logic [9:0] addr, input logic [63:0] wdata);
    @(negedge clk);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wdata;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  // One access on the default instance; cycle n is the n-th cycle after the handshake edge.
  task automatic access(input logic wr, input logic [9:0] addr, input logic [63:0] wdata,
                        input logic exp_err, input int exp_resp, input logic [63:0] exp_rd,
                        input int exp_ready);
    int n_resp, resp_cyc, ready_cyc;
    logic got_w, got_e;
    logic [63:0] got_d;
    n_resp = 0; resp_cyc = -1; ready_cyc = -1;
    got_w = 1'b0; got_e = 1'b0; got_d = '0;
    start(wr, addr, wdata);
    for (int n = 1; n <= 100 && ready_cyc < 0; n++) begin
      @(negedge clk);
      if (resp_valid) begin
        n_resp++;
        resp_cyc = n;
        got_w = resp_write;
        got_e = resp_err;
        got_d = resp_rdata;
      end
      if (req_ready) ready_cyc = n;
    end
    chk("resp_count", 64'(n_resp), 64'd1);
    chk("resp_cycle", 64'(resp_cyc), 64'(exp_resp));
    chk("resp_write", {63'd0, got_w}, {63'd0, wr && !exp_err});
    chk("resp_err", {63'd0, got_e}, {63'd0, exp_err});
    if (!wr && !exp_err) begin
      chk("resp_rdata", got_d, exp_rd);
      chk("rdata_hold", resp_rdata, exp_rd);
    end
    chk("ready_cycle", 64'(ready_cyc), 64'(exp_ready));
  endtask

  vec_t vecs[10];
  logic [15:0] beats[4];
  int bcnt, bfirst, wresp_cyc, rdy, nresp;

  initial begin
    vecs[0] = '{1'b1, 10'd5,    64'hDEAD_BEEF,           1'b0, 17, 64'h0,                   33};
    vecs[1] = '{1'b0, 10'd5,    64'h0,                   1'b0, 17, 64'hDEAD_BEEF,           26};
    vecs[2] = '{1'b1, 10'd3,    64'h1234,                1'b0, 17, 64'h0,                   33};
    vecs[3] = '{1'b0, 10'd3,    64'h0,                   1'b0, 17, 64'h1234,                26};
    vecs[4] = '{1'b0, 10'd100,  64'h0,                   1'b1, 1,  64'h0,                   1};
    vecs[5] = '{1'b1, 10'd1023, 64'hFFFF_FFFF,           1'b1, 1,  64'h0,                   1};
    vecs[6] = '{1'b1, 10'd99,   64'hA5A5_0000_FFFF_0001, 1'b0, 17, 64'h0,                   33};
    vecs[7] = '{1'b0, 10'd99,   64'h0,                   1'b0, 17, 64'hA5A5_0000_FFFF_0001, 26};
    vecs[8] = '{1'b0, 10'd5,    64'h0,                   1'b0, 17, 64'hDEAD_BEEF,           26};
    vecs[9] = '{1'b0, 10'd3,    64'h0,                   1'b0, 17, 64'h1234,                26};

    repeat (3) @(negedge clk);
    chk("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
    chk("rst_resp_err", {63'd0, resp_err}, 64'd0);
    chk("rst_resp_write", {63'd0, resp_write}, 64'd0);
    chk("rst_rdata", resp_rdata, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_req_ready", {63'd0, req_ready}, 64'd1);
    chk("rst_bl4_ready", {63'd0, b_req_ready}, 64'd1);

`ifdef DRAM_OPEN_PAGE_EN
    access(1'b1, 10'd7, 64'h77, 1'b0, 17, 64'h0,  25);
    access(1'b1, 10'd2, 64'h22, 1'b0, 25, 64'h0,  33);
    access(1'b0, 10'd2, 64'h0,  1'b0, 9,  64'h22, 10);
    access(1'b0, 10'd2, 64'h0,  1'b0, 9,  64'h22, 10);
    access(1'b0, 10'd7, 64'h0,  1'b0, 25, 64'h77, 26);
`else
    for (int i = 0; i < 10; i++)
      access(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].err,
             vecs[i].resp_cyc, vecs[i].rdata, vecs[i].ready_cyc);

    // Reset in the middle of a read of row 5.
    start(1'b0, 10'd5, 64'h0);
    nresp = 0;
    for (int n = 1; n < 10; n++) begin
      @(negedge clk);
      if (resp_valid) nresp++;
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_valid", {63'd0, resp_valid}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (resp_valid) nresp++;
    end
    chk("abort_no_resp", 64'(nresp), 64'd0);
    chk("abort_ready", {63'd0, req_ready}, 64'd1);
    access(1'b0, 10'd5, 64'h0, 1'b0, 17, 64'hDEAD_BEEF, 26);

    // BURST_LEN=4 instance: write one row, then read its beats back.
    @(negedge clk);
    b_req_valid = 1'b1; req_write = 1'b1; req_addr = 10'd1;
    req_wdata = 64'h4444_3333_2222_1111;
    @(posedge clk);
    #1 b_req_valid = 1'b0;
    wresp_cyc = -1; rdy = -1; nresp = 0;
    for (int n = 1; n <= 100 && rdy < 0; n++) begin
      @(negedge clk);
      if (b_resp_valid) begin
        nresp++;
        wresp_cyc = b_resp_write ? n : -2;
      end
      if (b_req_ready) rdy = n;
    end
    chk("bl4_wr_resp_count", 64'(nresp), 64'd1);
    chk("bl4_wr_resp_cycle", 64'(wresp_cyc), 64'd20);
    chk("bl4_wr_ready", 64'(rdy), 64'd36);

    @(negedge clk);
    b_req_valid = 1'b1; req_write = 1'b0; req_addr = 10'd1; req_wdata = '0;
    @(posedge clk);
    #1 b_req_valid = 1'b0;
    bcnt = 0; bfirst = -1; rdy = -1;
    for (int n = 1; n <= 100 && rdy < 0; n++) begin
      @(negedge clk);
      if (b_resp_valid) begin
        if (bfirst < 0) bfirst = n;
        if (bcnt < 4) beats[bcnt] = b_resp_rdata;
        bcnt++;
        chk("bl4_rd_resp_write", {63'd0, b_resp_write}, 64'd0);
      end
      if (b_req_ready) rdy = n;
    end
    chk("bl4_beat_count", 64'(bcnt), 64'd4);
    chk("bl4_first_beat_cycle", 64'(bfirst), 64'd17);
    chk("bl4_beat0", {48'd0, beats[0]}, 64'h1111);
    chk("bl4_beat1", {48'd0, beats[1]}, 64'h2222);
    chk("bl4_beat2", {48'd0, beats[2]}, 64'h3333);
    chk("bl4_beat3", {48'd0, beats[3]}, 64'h4444);
    chk("bl4_rd_ready", 64'(rdy), 64'd29);
    chk("bl4_rdata_hold", {48'd0, b_resp_rdata}, 64'h4444);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
